// File: rtl/dram_block_mover.sv
// dram_block_mover: word block copy / constant fill engine that masters the single-port data RAM
module dram_block_mover #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Start,
    input  logic                  Mode,
    input  logic [ADDR_WIDTH-1:0] SrcAddr,
    input  logic [ADDR_WIDTH-1:0] DstAddr,
    input  logic [ADDR_WIDTH-1:0] Length,
    input  logic [DATA_WIDTH-1:0] FillValue,
    input  logic                  Abort,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Aborted,
    output logic [ADDR_WIDTH-1:0] WordsDone,
    output logic [ADDR_WIDTH-1:0] DataAddress,
    output logic [ADDR_WIDTH-1:0] MemWriteIndex,
    output logic                  ReadMem,
    output logic                  WriteMem,
    output logic [DATA_WIDTH-1:0] DataIn,
    input  logic [DATA_WIDTH-1:0] DataOut
);
    // DEPTH is a power of two, so address wrap is a mask
    localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  aborted_q, aborted_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // Next-state, command registers, and RAM-side outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        words_d   = words_q;
        fill_d    = fill_q;
        buf_d     = buf_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: if (Start) begin
                mode_d    = Mode;
                src_d     = SrcAddr & MASK;
                dst_d     = DstAddr & MASK;
                rem_d     = Length;
                fill_d    = FillValue;
                words_d   = '0;
                aborted_d = 1'b0;
                state_d   = (Length == '0) ? DONE : Mode ? WRITE : READ;
            end
            READ: begin
                buf_d     = DataOut;
                aborted_d = Abort;
                state_d   = Abort ? DONE : WRITE;
            end
            WRITE: begin
                rem_d     = rem_q - ONE;
                words_d   = words_q + ONE;
                src_d     = (src_q + ONE) & MASK;
                dst_d     = (dst_q + ONE) & MASK;
                aborted_d = Abort;
                state_d   = (rem_q == ONE || Abort) ? DONE : mode_q ? WRITE : READ;
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == READ) || (state_d == WRITE);
        done_d  = state_d == DONE;
        rd_d    = state_d == READ;
        wr_d    = state_d == WRITE;
        daddr_d = rd_d ? src_d : '0;
        waddr_d = wr_d ? dst_d : '0;
        din_d   = wr_d ? (mode_d ? fill_d : buf_d) : '0;
    end

    // State and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            words_q   <= '0;
            fill_q    <= '0;
            buf_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            daddr_q   <= '0;
            waddr_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            words_q   <= words_d;
            fill_q    <= fill_d;
            buf_q     <= buf_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            daddr_q   <= daddr_d;
            waddr_q   <= waddr_d;
            din_q     <= din_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Aborted       = aborted_q;
    assign WordsDone     = words_q;
    assign DataAddress   = daddr_q;
    assign MemWriteIndex = waddr_q;
    assign ReadMem       = rd_q;
    assign WriteMem      = wr_q;
    assign DataIn        = din_q;
endmodule

// File: doc/dram_block_mover.md
Name: dram_block_mover

Overview:
- Bus initiator for the single-port data RAM. Drives the RAM's address, read-enable, write-enable and write-data lines, and consumes its combinational read data.
- Performs word block copy (RAM to RAM) or block fill (constant to RAM) under a start/done handshake.
- Sits beside the CPU datapath and is muxed onto the RAM port while Busy is high.

Parameters:
- DATA_WIDTH, 16, word width of RAM data.
- ADDR_WIDTH, 16, width of address ports.
- DEPTH, 256, RAM word count. Power of two. All address arithmetic wraps modulo DEPTH.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  synchronous active-low reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; latched at Start.
- SrcAddr  in  ADDR_WIDTH  copy source base; latched at Start.
- DstAddr  in  ADDR_WIDTH  destination base; latched at Start.
- Length  in  ADDR_WIDTH  word count; latched at Start.
- FillValue  in  DATA_WIDTH  fill word; latched at Start.
- Abort  in  1  stop request while Busy.
- Busy  out  1  high in READ or WRITE state.
- Done  out  1  one-cycle completion pulse.
- Aborted  out  1  high with Done if the transfer was cut short.
- WordsDone  out  ADDR_WIDTH  count of words written in the current or last command.
- DataAddress  out  ADDR_WIDTH  RAM read address.
- MemWriteIndex  out  ADDR_WIDTH  RAM write address.
- ReadMem  out  1  RAM read enable.
- WriteMem  out  1  RAM write enable; the RAM writes at posedge.
- DataIn  out  DATA_WIDTH  RAM write data.
- DataOut  in  DATA_WIDTH  RAM read data. Combinational from the RAM; Z when ReadMem=0.

Behaviour:
- Reset (RST_N=0 at posedge):
  - State goes to IDLE.
  - Busy, Done, Aborted, ReadMem and WriteMem go to 0.
  - DataAddress, MemWriteIndex, DataIn and WordsDone go to 0.
  - Reset mid-transfer abandons the transfer. Words already written stay in RAM. No Done pulse.
- States: IDLE, READ, WRITE, DONE.
- RAM-side outputs are decoded from state and registers only, never from inputs.
- IDLE:
  - All RAM enables are 0.
  - On Start=1, latch the command. src_ptr = SrcAddr mod DEPTH, dst_ptr = DstAddr mod DEPTH, remaining = Length, WordsDone = 0, Aborted = 0.
  - Next state: DONE if Length=0; WRITE if Mode=1; otherwise READ.
- READ (copy only):
  - ReadMem=1 and DataAddress=src_ptr.
  - At posedge, capture DataOut into buf and go to WRITE.
  - DataOut is never sampled outside READ.
- WRITE:
  - WriteMem=1, MemWriteIndex=dst_ptr, DataIn = (Mode ? fill : buf).
  - At posedge: remaining--, WordsDone++, src_ptr=(src_ptr+1) mod DEPTH, dst_ptr=(dst_ptr+1) mod DEPTH.
  - Next state is DONE if remaining was 1 or Abort=1. Otherwise it is WRITE (fill) or READ (copy).
- DONE:
  - Done=1 for exactly one cycle, Busy=0, then IDLE.
  - Start in DONE is ignored.
- Throughput: copy takes 2 cycles/word; fill takes 1 cycle/word. For N>0, Done asserts in cycle 2N+1 (copy) or N+1 (fill) after the Start-sampling edge. For Length=0, Done asserts in the cycle after the Start edge.
- Abort:
  - Abort sampled in READ: go to DONE with Aborted=1. No write occurs.
  - Abort sampled in WRITE: the current write completes and is counted, then DONE with Aborted=1.
  - Abort is ignored in IDLE and DONE.
  - If Abort and the last word coincide, Aborted=1.
- Start while Busy is ignored. Command inputs may change freely after the Start edge.
- Overlap: copy is strictly ascending, read-then-write per word. With dst in (src, src+Length), the first source word propagates forward. This is defined behaviour, not an error.
- WordsDone holds after DONE until the next accepted Start.
- Length is unsigned. Lengths greater than DEPTH wrap around the address space and rewrite locations.

Test Plan:
1. Copy, mem[0x10..0x13]=1,2,3,4, Src=0x10 Dst=0x40 Len=4 → alternating ReadMem/WriteMem for 8 cycles; Done in cycle 9; mem[0x40..0x43]=1,2,3,4; WordsDone=4, Aborted=0.
2. Fill, Dst=0xFE Len=3 Fill=0xBEEF → WriteMem=1 for 3 consecutive cycles at indices 0xFE, 0xFF, 0x00 (wrap); ReadMem never 1; Done in cycle 4.
3. Len=0 → Done in the next cycle; ReadMem and WriteMem stay 0; WordsDone=0.
4. Overlap: mem[0x20]=0xA, Src=0x20 Dst=0x21 Len=3 → mem[0x21..0x23]=0xA.
5. Copy Len=4, Abort pulsed in the second READ → exactly one write; Done with Aborted=1; WordsDone=1. Repeat with Abort in the second WRITE → WordsDone=2.
6. Start copy Len=4, pulse Start again in cycle 2 (ignored), drive RST_N=0 in cycle 4 → IDLE next cycle, all outputs 0, no Done, no further writes; a later Start runs normally.
